// File: rtl/pio_edge_capture_irq_pkg.sv
// Shared constants for the PIO edge-capture interrupt slave: bus widths and
// the register word addresses.
package pio_edge_capture_irq_pkg;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_RISE_EN  = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_FALL_EN  = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_EDGE_CAP = 3'd4;

endpackage

// File: rtl/pio_edge_capture_irq_if.sv
// Avalon-MM slave bus of the edge-capture block, shared by the RTL and the bench.
interface pio_edge_capture_irq_if;
    import pio_edge_capture_irq_pkg::*;

    // Handshake: a write commits on the clock edge where chipselect & ~write_n.
    // There is no waitrequest; readdata is the registered address mux and is
    // valid one clock after address is presented, whether or not chipselect is set.
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/pio_edge_capture_irq_debounce_bit.sv
// One monitored pin: 2-flop synchronizer followed by a stable-count debouncer.
// DEBOUNCE_CYCLES = 0 turns the debounced value into the synchronizer output.
module pio_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic debounced
);

    logic sync0;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0  <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            sync0  <= pin;
            sync_q <= sync0;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign debounced = sync_q;
        end else begin : g_debounce
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
            logic [CNT_W-1:0] cnt;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    cnt       <= '0;
                    debounced <= 1'b0;
                end else if (sync_q == debounced) begin
                    cnt <= '0;
                end else if (sync0 != sync_q) begin
                    // sync_q is about to move again, so the stable window restarts
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    debounced <= sync_q;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/pio_edge_capture_irq.sv
// Avalon-MM slave that debounces the PIO input pins, latches enabled rising and
// falling edges into a sticky W1C register and raises a masked level interrupt.
module pio_edge_capture_irq
    import pio_edge_capture_irq_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [WIDTH-1:0]      pin_in,
    pio_edge_capture_irq_if.slave bus,
    output logic                  irq
);

    logic [WIDTH-1:0]  debounced;
    logic [WIDTH-1:0]  debounced_prev;
    logic [WIDTH-1:0]  rise_en;
    logic [WIDTH-1:0]  fall_en;
    logic [WIDTH-1:0]  irq_mask;
    logic [WIDTH-1:0]  edge_cap;
    logic [WIDTH-1:0]  edge_hit;
    logic [WIDTH-1:0]  wdata_w;
    logic [WIDTH-1:0]  w1c;
    logic              wr;
    logic [DATA_W-1:0] rd_mux;
    logic              unused_wdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        pio_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_debounce (
            .clk       (clk),
            .reset_n   (reset_n),
            .pin       (pin_in[i]),
            .debounced (debounced[i])
        );
    end

    assign wr           = bus.chipselect & ~bus.write_n;
    assign wdata_w      = bus.writedata[WIDTH-1:0];
    assign unused_wdata = ^bus.writedata;
    assign w1c          = (wr && bus.address == ADDR_EDGE_CAP) ? wdata_w : '0;
    assign edge_hit     = (debounced & ~debounced_prev & rise_en) |
                          (~debounced & debounced_prev & fall_en);

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:     rd_mux[WIDTH-1:0] = debounced;
            ADDR_RISE_EN:  rd_mux[WIDTH-1:0] = rise_en;
            ADDR_FALL_EN:  rd_mux[WIDTH-1:0] = fall_en;
            ADDR_IRQ_MASK: rd_mux[WIDTH-1:0] = irq_mask;
            ADDR_EDGE_CAP: rd_mux[WIDTH-1:0] = edge_cap;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            debounced_prev <= '0;
            rise_en        <= '0;
            fall_en        <= '0;
            irq_mask       <= '0;
            edge_cap       <= '0;
            irq            <= 1'b0;
            bus.readdata   <= '0;
        end else begin
            debounced_prev <= debounced;
            if (wr && bus.address == ADDR_RISE_EN)  rise_en  <= wdata_w;
            if (wr && bus.address == ADDR_FALL_EN)  fall_en  <= wdata_w;
            if (wr && bus.address == ADDR_IRQ_MASK) irq_mask <= wdata_w;
            // A fresh edge overrides a clear of the same bit in the same clock
            edge_cap       <= (edge_cap & ~w1c) | edge_hit;
            irq            <= |(edge_cap & irq_mask);
            bus.readdata   <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pio_edge_capture_irq.sv
// Bench for pio_edge_capture_irq: one debounced instance (DEBOUNCE_CYCLES=4)
// and one bypass instance (DEBOUNCE_CYCLES=0) sharing clock and reset.
module tb_pio_edge_capture_irq;
  import pio_edge_capture_irq_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] pin_in;
  logic [W-1:0] pin_in_b;
  logic         irq;
  logic         irq_b;

  logic [31:0] exp_q[$];
  int          pass_cnt;
  int          total_cnt;

  pio_edge_capture_irq_if bus ();
  pio_edge_capture_irq_if bus_b ();

  pio_edge_capture_irq #(
    .WIDTH(W), .DEBOUNCE_CYCLES(4), .CNT_W(5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .pin_in(pin_in), .bus(bus), .irq(irq)
  );

  pio_edge_capture_irq #(
    .WIDTH(W), .DEBOUNCE_CYCLES(0), .CNT_W(5)
  ) dut_byp (
    .clk(clk), .reset_n(reset_n), .pin_in(pin_in_b), .bus(bus_b), .irq(irq_b)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic bus_write(input bit b, input logic [2:0] a, input logic [31:0] d);
    if (b) begin
      bus_b.address = a; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b0; bus_b.writedata = d;
    end else begin
      bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.writedata = d;
    end
    tick();
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
    bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
  endtask

  task automatic bus_addr(input bit b, input logic [2:0] a);
    if (b) begin
      bus_b.address = a; bus_b.chipselect = 1'b1; bus_b.write_n = 1'b1;
    end else begin
      bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [31:0] e;
    bus_write(0, ADDR_RISE_EN, 32'hFF);
    bus_write(0, ADDR_FALL_EN, 32'hFF);
    bus_write(0, ADDR_IRQ_MASK, 32'hFF);
    pin_in = 8'h5A;
    repeat (10) tick();
    #3 reset_n = 1'b0;
    pin_in = '0;
    #1;
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); total_cnt++;
    if ({31'b0, irq} !== e) $display("FAIL reset_async_irq: got %h expected %h", irq, e);
    else pass_cnt++;
    tick(); tick();
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus_addr(0, 3'(a));
      exp_q.push_back(32'h0);
      tick();
      e = exp_q.pop_front(); total_cnt++;
      if (bus.readdata !== e) $display("FAIL reset_read addr%0d: got %h expected %h", a, bus.readdata, e);
      else pass_cnt++;
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); total_cnt++;
      if ({31'b0, irq} !== e) $display("FAIL reset_irq addr%0d: got %h expected %h", a, irq, e);
      else pass_cnt++;
    end
    bus_write(0, ADDR_DATA, 32'hFF);
    bus_addr(0, ADDR_DATA);
    exp_q.push_back(32'h0);
    tick();
    e = exp_q.pop_front(); total_cnt++;
    if (bus.readdata !== e) $display("FAIL data_ro_write: got %h expected %h", bus.readdata, e);
    else pass_cnt++;
  endtask

  task automatic test_reset_requalify();
    logic [31:0] e;
    pin_in = 8'h08;
    repeat (3) tick();
    #2 reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    bus_write(0, ADDR_RISE_EN, 32'h08);
    bus_addr(0, ADDR_DATA);
    exp_q.push_back(32'h0);
    tick();
    e = exp_q.pop_front(); total_cnt++;
    if (bus.readdata !== e) $display("FAIL requal_data_cleared: got %h expected %h", bus.readdata, e);
    else pass_cnt++;
    repeat (7) tick();
    bus_addr(0, ADDR_EDGE_CAP);
    exp_q.push_back(32'h08);
    tick();
    e = exp_q.pop_front(); total_cnt++;
    if (bus.readdata !== e) $display("FAIL requal_edge_cap: got %h expected %h", bus.readdata, e);
    else pass_cnt++;
    bus_addr(0, ADDR_DATA);
    exp_q.push_back(32'h08);
    tick();
    e = exp_q.pop_front(); total_cnt++;
    if (bus.readdata !== e) $display("FAIL requal_data: got %h expected %h", bus.readdata, e);
    else pass_cnt++;
    bus_write(0, ADDR_RISE_EN, 32'h0);
    bus_write(0, ADDR_EDGE_CAP, 32'hFF);
    pin_in = '0;
    repeat (10) tick();
  endtask

  task automatic test_debounce_latency();
    logic [31:0] e;
    bus_addr(0, ADDR_DATA);
    pin_in = 8'h01;
    for (int n = 1; n <= 10; n++) begin
      exp_q.push_back((n >= 7) ? 32'h01 : 32'h00);
      tick();
      e = exp_q.pop_front(); total_cnt++;
      if (bus.readdata !== e) $display("FAIL deb_latency n=%0d: got %h expected %h", n, bus.readdata, e);
      else pass_cnt++;
    end
    pin_in = 8'h03;
    for (int n = 0; n < 3; n++) begin
      exp_q.push_back(32'h01);
      tick();
      e = exp_q.pop_front(); total_cnt++;
      if (bus.readdata !== e) $display("FAIL deb_glitch_hi n=%0d: got %h expected %h", n, bus.readdata, e);
      else pass_cnt++;
    end
    pin_in = 8'h01;
    for (int n = 0; n < 10; n++) begin
      exp_q.push_back(32'h01);
      tick();
      e = exp_q.pop_front(); total_cnt++;
      if (bus.readdata !== e) $display("FAIL deb_glitch_after n=%0d: got %h expected %h", n, bus.readdata, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_rise_irq();
    logic [31:0] e;
    pin_in = 8'h00;
    repeat (10) tick();
    bus_write(0, ADDR_RISE_EN, 32'h01);
    bus_write(0, ADDR_IRQ_MASK, 32'h01);
    bus_addr(0, ADDR_EDGE_CAP);
    pin_in = 8'h01;
    for (int n = 1; n <= 9; n++) begin
      tick();
      exp_q.push_back((n >= 8) ? 32'h01 : 32'h00);
      e = exp_q.pop_front(); total_cnt++;
      if (bus.readdata !== e) $display("FAIL rise_edge_cap n=%0d: got %h expected %h", n, bus.readdata, e);
      else pass_cnt++;
      exp_q.push_back((n >= 8) ? 32'h01 : 32'h00);
      e = exp_q.pop_front(); total_cnt++;
      if ({31'b0, irq} !== e) $display("FAIL rise_irq n=%0d: got %h expected %h", n, irq, e);
      else pass_cnt++;
    end
    bus_write(0, ADDR_EDGE_CAP, 32'h01);
    exp_q.push_back(32'h1);
    e = exp_q.pop_front(); total_cnt++;
    if ({31'b0, irq} !== e) $display("FAIL irq_at_clear: got %h expected %h", irq, e);
    else pass_cnt++;
    tick();
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); total_cnt++;
    if ({31'b0, irq} !== e) $display("FAIL irq_after_clear: got %h expected %h", irq, e);
    else pass_cnt++;
    bus_addr(0, ADDR_EDGE_CAP);
    exp_q.push_back(32'h0);
    tick();
    e = exp_q.pop_front(); total_cnt++;
    if (bus.readdata !== e) $display("FAIL edge_cap_cleared: got %h expected %h", bus.readdata, e);
    else pass_cnt++;
  endtask

  task automatic test_fall_mask();
    logic [31:0] e;
    pin_in = 8'h81;
    repeat (10) tick();
    bus_write(0, ADDR_FALL_EN, 32'h80);
    bus_write(0, ADDR_IRQ_MASK, 32'h00);
    pin_in = 8'h01;
    for (int n = 1; n <= 10; n++) begin
      tick();
      exp_q.push_back(32'h0);
      e = exp_q.pop_front(); total_cnt++;
      if ({31'b0, irq} !== e) $display("FAIL fall_masked_irq n=%0d: got %h expected %h", n, irq, e);
      else pass_cnt++;
    end
    bus_addr(0, ADDR_EDGE_CAP);
    exp_q.push_back(32'h80);
    tick();
    e = exp_q.pop_front(); total_cnt++;
    if (bus.readdata !== e) $display("FAIL fall_edge_cap: got %h expected %h", bus.readdata, e);
    else pass_cnt++;
    bus_write(0, ADDR_IRQ_MASK, 32'h80);
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); total_cnt++;
    if ({31'b0, irq} !== e) $display("FAIL unmask_same_clk: got %h expected %h", irq, e);
    else pass_cnt++;
    tick();
    exp_q.push_back(32'h1);
    e = exp_q.pop_front(); total_cnt++;
    if ({31'b0, irq} !== e) $display("FAIL unmask_next_clk: got %h expected %h", irq, e);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    logic [31:0] e;
    bus_write(0, ADDR_RISE_EN, 32'h04);
    bus_write(0, ADDR_IRQ_MASK, 32'h84);
    pin_in = 8'h05;
    repeat (6) tick();
    bus_write(0, ADDR_EDGE_CAP, 32'h84);
    for (int n = 0; n < 2; n++) begin
      exp_q.push_back(32'h1);
      e = exp_q.pop_front(); total_cnt++;
      if ({31'b0, irq} !== e) $display("FAIL collide_irq n=%0d: got %h expected %h", n, irq, e);
      else pass_cnt++;
      if (n == 0) tick();
    end
    bus_addr(0, ADDR_EDGE_CAP);
    exp_q.push_back(32'h04);
    tick();
    e = exp_q.pop_front(); total_cnt++;
    if (bus.readdata !== e) $display("FAIL collide_edge_cap: got %h expected %h", bus.readdata, e);
    else pass_cnt++;
    bus_write(0, ADDR_RISE_EN, 32'h0);
    bus_addr(0, ADDR_EDGE_CAP);
    exp_q.push_back(32'h04);
    tick();
    e = exp_q.pop_front(); total_cnt++;
    if (bus.readdata !== e) $display("FAIL sticky_after_disable: got %h expected %h", bus.readdata, e);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    logic [31:0] e;
    logic        v;
    bus_write(1, ADDR_RISE_EN, 32'h01);
    bus_addr(1, ADDR_DATA);
    v = 1'b0;
    for (int s = 0; s < 24; s++) begin
      if (s % 3 == 0) v = ~v;
      pin_in_b = {7'b0, v};
      exp_q.push_back({31'b0, v});
      tick();
      if (exp_q.size() == 3) begin
        e = exp_q.pop_front(); total_cnt++;
        if (bus_b.readdata !== e) $display("FAIL bypass_track s=%0d: got %h expected %h", s, bus_b.readdata, e);
        else pass_cnt++;
      end
    end
    for (int s = 0; s < 2; s++) begin
      tick();
      e = exp_q.pop_front(); total_cnt++;
      if (bus_b.readdata !== e) $display("FAIL bypass_drain s=%0d: got %h expected %h", s, bus_b.readdata, e);
      else pass_cnt++;
    end
    for (int k = 0; k < 3; k++) begin
      pin_in_b = '0;
      repeat (4) tick();
      bus_write(1, ADDR_EDGE_CAP, 32'h01);
      bus_addr(1, ADDR_EDGE_CAP);
      exp_q.push_back(32'h0);
      tick();
      e = exp_q.pop_front(); total_cnt++;
      if (bus_b.readdata !== e) $display("FAIL bypass_cleared k=%0d: got %h expected %h", k, bus_b.readdata, e);
      else pass_cnt++;
      pin_in_b = 8'h01;
      repeat (4) tick();
      exp_q.push_back(32'h01);
      tick();
      e = exp_q.pop_front(); total_cnt++;
      if (bus_b.readdata !== e) $display("FAIL bypass_rise k=%0d: got %h expected %h", k, bus_b.readdata, e);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset_n   = 1'b0;
    pin_in    = '0;
    pin_in_b  = '0;
    bus.address   = '0; bus.chipselect   = 1'b0; bus.write_n   = 1'b1; bus.writedata   = '0;
    bus_b.address = '0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    test_reset();
    test_reset_requalify();
    test_debounce_latency();
    test_rise_irq();
    test_fall_mask();
    test_collision();
    test_bypass();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
